// File: rtl/regfile_pkg.sv
// Shared constants and types for the 16x32 register file and its access scheduler.
package regfile_pkg;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;

  typedef logic [ADDR_W-1:0]   reg_addr_t;
  typedef logic [DATA_W-1:0]   reg_data_t;
  typedef logic [NUM_REGS-1:0] busy_vec_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;

  typedef enum logic {
    PTR_WB0 = 1'b0,
    PTR_WB1 = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer names the requester favoured on a tie.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  rr_ptr_e ptr, ptr_next;

  always_comb begin
    gnt      = 2'b00;
    ptr_next = ptr;
    if (req == 2'b11) begin
      gnt = (ptr == PTR_WB0) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
    // After any grant the other requester gets priority, even if it was idle.
    if (gnt[0]) begin
      ptr_next = PTR_WB1;
    end else if (gnt[1]) begin
      ptr_next = PTR_WB0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= PTR_WB0;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/regfile_scheduler.sv
// Issue/writeback sequencer for the 2R1W register file: scoreboard hazard stall,
// read-port drive on issue, and round-robin sharing of the single write port.
module regfile_scheduler
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       iss_valid,
  output logic       iss_ready,
  input  logic [1:0] iss_use_src,
  input  reg_addr_t  iss_src0,
  input  reg_addr_t  iss_src1,
  input  logic       iss_has_dst,
  input  reg_addr_t  iss_dst,
  output logic       opr_valid,
  input  logic       wb0_valid,
  input  logic       wb1_valid,
  output logic       wb0_ready,
  output logic       wb1_ready,
  input  reg_addr_t  wb0_addr,
  input  reg_addr_t  wb1_addr,
  input  reg_data_t  wb0_data,
  input  reg_data_t  wb1_data,
  output logic [1:0] rf_read_en,
  output reg_addr_t  rf_raddr_0,
  output reg_addr_t  rf_raddr_1,
  output logic       rf_write_en,
  output reg_addr_t  rf_waddr,
  output reg_data_t  rf_wdata,
  output busy_vec_t  busy_vec,
  output logic       err_wb_unowned
);

  wb_req_t   wb0_req, wb1_req, wb_sel;
  logic [1:0] gnt;
  logic       iss_fire, wb_fire;
  busy_vec_t  busy_set, busy_clr;

  assign wb0_req = '{valid: wb0_valid, addr: wb0_addr, data: wb0_data};
  assign wb1_req = '{valid: wb1_valid, addr: wb1_addr, data: wb1_data};

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({wb1_req.valid, wb0_req.valid}),
    .gnt     (gnt)
  );

  assign wb0_ready = gnt[0];
  assign wb1_ready = gnt[1];
  assign wb_fire   = |gnt;
  assign wb_sel    = gnt[1] ? wb1_req : wb0_req;

  assign iss_ready = !(iss_use_src[0] && busy_vec[iss_src0]) &&
                     !(iss_use_src[1] && busy_vec[iss_src1]) &&
                     !(iss_has_dst    && busy_vec[iss_dst]);
  assign iss_fire  = iss_valid && iss_ready;

  // Clear comes from the registered write so busy drops only once the RF has the data.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (iss_fire && iss_has_dst) begin
      busy_set[iss_dst] = 1'b1;
    end
    if (rf_write_en) begin
      busy_clr[rf_waddr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= (busy_vec & ~busy_clr) | busy_set;
    end
  end

  // Read-port stage: one cycle after accept the RF outputs are valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opr_valid  <= 1'b0;
      rf_read_en <= 2'b00;
      rf_raddr_0 <= '0;
      rf_raddr_1 <= '0;
    end else begin
      opr_valid  <= iss_fire;
      rf_read_en <= 2'b00;
      if (iss_fire) begin
        rf_read_en <= iss_use_src;
        rf_raddr_0 <= iss_use_src[0] ? iss_src0 : '0;
        rf_raddr_1 <= iss_use_src[1] ? iss_src1 : '0;
      end
    end
  end

  // Write-port stage: address/data hold between writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_write_en    <= 1'b0;
      rf_waddr       <= '0;
      rf_wdata       <= '0;
      err_wb_unowned <= 1'b0;
    end else begin
      rf_write_en <= wb_fire;
      if (wb_fire) begin
        rf_waddr <= wb_sel.addr;
        rf_wdata <= wb_sel.data;
        if (!busy_vec[wb_sel.addr]) begin
          err_wb_unowned <= 1'b1;
        end
      end
    end
  end

endmodule
